// File: rtl/seq_mult.sv
// Multi-cycle radix-2 shift-and-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_mult #(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [WA-1:0]     a,
    input  logic [WB-1:0]     b,
    output logic              busy,
    output logic              done,
    output logic [WA+WB-1:0]  product
);

    localparam int unsigned CW = $clog2(WB + 1);
    localparam int unsigned PW = WA + WB;
`ifdef SEQ_MULT_SIGNED_EN
    // One extra bit so the most-negative operand's magnitude is representable.
    localparam int unsigned AW = WA + 1;
    localparam int unsigned BW = WB + 1;
`else
    localparam int unsigned AW = WA;
    localparam int unsigned BW = WB;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_sh;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            load_c;
    logic            step_c;
    logic            last_c;
    logic [AW-1:0]   a_mag_c;
    logic [BW-1:0]   b_mag_c;
    logic [PW-1:0]   addend_c;
    logic [PW-1:0]   acc_nxt_c;
    logic [PW-1:0]   result_c;

    // Operand conditioning: magnitudes (signed build) or plain copies.
`ifdef SEQ_MULT_SIGNED_EN
    logic            neg;
    logic            neg_c;
    logic [AW-1:0]   a_ext_c;
    logic [BW-1:0]   b_ext_c;

    always_comb begin
        a_ext_c = {a[WA-1], a};
        b_ext_c = {b[WB-1], b};
        a_mag_c = a[WA-1] ? AW'(~a_ext_c + AW'(1)) : a_ext_c;
        b_mag_c = b[WB-1] ? BW'(~b_ext_c + BW'(1)) : b_ext_c;
        neg_c   = a[WA-1] ^ b[WB-1];
    end
`else
    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes and datapath arithmetic for this cycle.
    always_comb begin
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        addend_c  = '0;
        acc_nxt_c = acc;
        result_c  = acc;
        case (state)
            IDLE: begin
                load_c = start;
            end
            RUN: begin
                step_c = 1'b1;
                last_c = (cnt == CW'(WB - 1));
            end
            default: ;
        endcase
        if (b_sh[0]) begin
            addend_c = PW'(a_q) << cnt;
        end
        acc_nxt_c = acc + addend_c;
`ifdef SEQ_MULT_SIGNED_EN
        result_c  = neg ? PW'(~acc_nxt_c + PW'(1)) : acc_nxt_c;
`else
        result_c  = acc_nxt_c;
`endif
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_q     <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                a_q  <= a_mag_c;
                b_sh <= b_mag_c;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end
            if (step_c) begin
                acc  <= acc_nxt_c;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (last_c) begin
                    product <= result_c;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

`ifdef SEQ_MULT_SIGNED_EN
    // Result sign is fixed at accept time.
    always_ff @(posedge clk) begin
        if (clr) begin
            neg <= 1'b0;
        end else if (load_c) begin
            neg <= neg_c;
        end
    end
`endif

endmodule
